// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the MEM->WB pipeline stage.
//               Lane layouts for the writeback bundle and the debug-commit
//               record, default widths, and the architectural zero register.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    // Writes to this register address are architecturally discarded.
    localparam int NOP_REG    = 0;

    // One lane of the writeback bundle (shown at default widths).
    typedef struct packed {
        logic [DEF_REG_AW-1:0] wd;
        logic                  wreg;
        logic [DEF_DATA_W-1:0] wdata;
    } wb_lane_t;

    // One lane of the debug-commit record. The delay line packs lanes in
    // this same field order: {pc, instr, valid}, valid in the LSB.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
        logic                  valid;
    } commit_lane_t;

    // Bit width of one commit_lane_t-shaped record at an arbitrary data width.
    function automatic int commit_lane_width(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/commit_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : commit_delay_line
// Description : Free-running shift register of DEPTH stages with an
//               asynchronous clear. Every bit of the word travels through
//               identical stages, so all fields stay aligned.
// Ports       : clk  - clock
//               rst  - asynchronous active-high clear of every stage
//               d_i  - word entering stage 0
//               q_o  - word leaving the last stage (DEPTH cycles later)
// Revision    : 1.0 - initial release
// ============================================================================
module commit_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("commit_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule : commit_delay_line
`default_nettype wire

// File: rtl/mem_wb_multi.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_multi
// Description : N-lane MEM->WB pipeline register with stall/flush control,
//               qualified regfile write enables, an aligned debug-commit
//               delay line and a committed-instruction counter.
// Ports       : clk, rst             - clock, async active-high reset
//               stall, flush         - hold WB / load a bubble (flush wins)
//               mem_wd/wreg/wdata    - per-lane writeback request from MEM
//               mem_inst_pc/instr    - per-lane commit info from MEM
//               mem_inst_valid       - lane holds a real instruction
//               wb_wd/wreg/wdata     - registered regfile write port
//               debug_commit_*       - delayed, aligned commit record
//               commit_count         - running count of reported commits
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_multi
    import pipe_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int REG_AW       = DEF_REG_AW,
    parameter int COMMIT_DELAY = 2,
    parameter int CNT_W        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [LANES*REG_AW-1:0]  mem_wd,
    input  logic [LANES-1:0]         mem_wreg,
    input  logic [LANES*DATA_W-1:0]  mem_wdata,
    input  logic [LANES*DATA_W-1:0]  mem_inst_pc,
    input  logic [LANES*DATA_W-1:0]  mem_instr,
    input  logic [LANES-1:0]         mem_inst_valid,
    output logic [LANES*REG_AW-1:0]  wb_wd,
    output logic [LANES-1:0]         wb_wreg,
    output logic [LANES*DATA_W-1:0]  wb_wdata,
    output logic [LANES*DATA_W-1:0]  debug_commit_pc,
    output logic [LANES*DATA_W-1:0]  debug_commit_instr,
    output logic [LANES-1:0]         debug_commit_valid,
    output logic [CNT_W-1:0]         commit_count
);

    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("mem_wb_multi: LANES must be in 1..4");
    end
    if (COMMIT_DELAY < 0 || COMMIT_DELAY > 4) begin : g_bad_delay
        $error("mem_wb_multi: COMMIT_DELAY must be in 0..4");
    end

    localparam int LANE_W = commit_lane_width(DATA_W);
    localparam int LINE_W = LANES * LANE_W;

    // ------------------------------------------------------------------
    // Writeback register
    // ------------------------------------------------------------------
    logic [LANES*REG_AW-1:0] wd_q,    wd_d;
    logic [LANES-1:0]        wreg_q,  wreg_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;

    // MEM contents are consumed only on a normal advance.
    logic advance;
    assign advance = !stall && !flush;

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (flush) begin
            wd_d    = '0;
            wreg_d  = '0;
            wdata_d = '0;
        end else if (!stall) begin
            wd_d    = mem_wd;
            wdata_d = mem_wdata;
            for (int i = 0; i < LANES; i++) begin
                // Bubbles and r0 writes never reach the regfile.
                wreg_d[i] = mem_wreg[i] & mem_inst_valid[i]
                          & (mem_wd[i*REG_AW +: REG_AW] != REG_AW'(NOP_REG));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb_wd    = wd_q;
    assign wb_wreg  = wreg_q;
    assign wb_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Debug-commit delay line. Stage 0 is the WB capture itself, so the
    // line has COMMIT_DELAY+1 stages. pc/instr are captured every cycle;
    // only valid is gated, which keeps a held instruction from being
    // reported again while WB is stalled.
    // ------------------------------------------------------------------
    logic [LINE_W-1:0] capture_d;
    logic [LINE_W-1:0] tap;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign capture_d[g*LANE_W +: LANE_W] = {mem_inst_pc[g*DATA_W +: DATA_W],
                                                mem_instr[g*DATA_W +: DATA_W],
                                                mem_inst_valid[g] & advance};

        assign debug_commit_pc[g*DATA_W +: DATA_W]    = tap[g*LANE_W + DATA_W + 1 +: DATA_W];
        assign debug_commit_instr[g*DATA_W +: DATA_W] = tap[g*LANE_W + 1 +: DATA_W];
        assign debug_commit_valid[g]                  = tap[g*LANE_W];
    end

    commit_delay_line #(
        .DEPTH (COMMIT_DELAY + 1),
        .WIDTH (LINE_W)
    ) u_commit_delay_line (
        .clk (clk),
        .rst (rst),
        .d_i (capture_d),
        .q_o (tap)
    );

    // ------------------------------------------------------------------
    // Commit counter: counts what is reported at the tap, so it trails
    // the visible pulse by one cycle and wraps freely.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] tap_pop;

    always_comb begin
        tap_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            tap_pop = tap_pop + CNT_W'(debug_commit_valid[i]);
        end
        count_d = count_q + tap_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign commit_count = count_q;

endmodule : mem_wb_multi
`default_nettype wire

// File: tb/tb_mem_wb_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_multi
// Description : Self-checking bench for mem_wb_multi (LANES=2,
//               COMMIT_DELAY=2, CNT_W=4) with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_multi;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CD     = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    stall, flush;
    logic [LANES*REG_AW-1:0] mem_wd;
    logic [LANES-1:0]        mem_wreg;
    logic [LANES*DATA_W-1:0] mem_wdata, mem_inst_pc, mem_instr;
    logic [LANES-1:0]        mem_inst_valid;
    logic [LANES*REG_AW-1:0] wb_wd;
    logic [LANES-1:0]        wb_wreg;
    logic [LANES*DATA_W-1:0] wb_wdata;
    logic [LANES*DATA_W-1:0] debug_commit_pc, debug_commit_instr;
    logic [LANES-1:0]        debug_commit_valid;
    logic [CNT_W-1:0]        commit_count;

    mem_wb_multi #(
        .LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW),
        .COMMIT_DELAY(CD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_inst_pc(mem_inst_pc), .mem_instr(mem_instr),
        .mem_inst_valid(mem_inst_valid),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .debug_commit_pc(debug_commit_pc), .debug_commit_instr(debug_commit_instr),
        .debug_commit_valid(debug_commit_valid), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [LANES-1:0]        v;
        logic [LANES*DATA_W-1:0] pc;
        logic [LANES*DATA_W-1:0] instr;
    } cap_t;

    cap_t                    hist[$];   // one capture per clock edge, newest last
    logic [LANES*REG_AW-1:0] m_wd;
    logic [LANES-1:0]        m_wreg;
    logic [LANES*DATA_W-1:0] m_wdata;
    int                      m_count;

    // What the debug port should show: the capture from CD edges ago.
    function automatic cap_t exp_dbg();
        cap_t z;
        z.v = '0; z.pc = '0; z.instr = '0;
        if (hist.size() > CD) return hist[hist.size()-1-CD];
        return z;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_wd = '0; m_wreg = '0; m_wdata = '0; m_count = 0;
    endtask

    // Advance DUT and model by one clock edge; sample point is #1 after it.
    task automatic cycle();
        cap_t                    c, cur;
        logic [LANES*REG_AW-1:0] nwd;
        logic [LANES-1:0]        nwreg;
        logic [LANES*DATA_W-1:0] ndata;
        cur = exp_dbg();
        nwd = m_wd; nwreg = m_wreg; ndata = m_wdata;
        if (flush) begin
            nwd = '0; nwreg = '0; ndata = '0;
        end else if (!stall) begin
            nwd = mem_wd; ndata = mem_wdata;
            for (int l = 0; l < LANES; l++)
                nwreg[l] = mem_wreg[l] & mem_inst_valid[l] & (mem_wd[l*REG_AW +: REG_AW] != '0);
        end
        c.v     = (flush || stall) ? '0 : mem_inst_valid;
        c.pc    = mem_inst_pc;
        c.instr = mem_instr;
        @(posedge clk);
        #1;
        m_wd = nwd; m_wreg = nwreg; m_wdata = ndata;
        hist.push_back(c);
        while (hist.size() > CD + 1) void'(hist.pop_front());
        m_count = (m_count + $countones(cur.v)) % (1 << CNT_W);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        stall = 1'b0; flush = 1'b0;
        mem_wd = '0; mem_wreg = '0; mem_wdata = '0;
        mem_inst_pc = '0; mem_instr = '0; mem_inst_valid = '0;
    endtask

    task automatic set_random();
        mem_wd         = (LANES*REG_AW)'($urandom);
        mem_wreg       = LANES'($urandom);
        mem_wdata      = {$urandom, $urandom};
        mem_inst_pc    = {$urandom, $urandom};
        mem_instr      = {$urandom, $urandom};
        mem_inst_valid = LANES'($urandom);
    endtask

    task automatic drain();
        set_idle();
        repeat (CD + 2) cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (5) begin
            set_random();
            cycle();
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({wb_wd, wb_wreg, wb_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_wb: got wd=%h wreg=%b wdata=%h want all 0", wb_wd, wb_wreg, wb_wdata);
        end
        checks++;
        if ({debug_commit_pc, debug_commit_instr, debug_commit_valid} !== '0) begin
            errors++;
            $display("FAIL reset_debug: got pc=%h instr=%h valid=%b want all 0",
                     debug_commit_pc, debug_commit_instr, debug_commit_valid);
        end
        checks++;
        if (commit_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", commit_count);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_passthrough();
        int base;
        drain();
        base = m_count;
        set_idle();
        mem_wd[4:0] = 5'd3; mem_wreg[0] = 1'b1; mem_wdata[31:0] = 32'hDEADBEEF;
        mem_inst_pc[31:0] = 32'h1C000000; mem_instr[31:0] = 32'h00100093; mem_inst_valid[0] = 1'b1;
        mem_wd[9:5] = 5'd9; mem_wreg[1] = 1'b1;   // lane 1 invalid
        cycle();
        checks++;
        if (wb_wreg !== 2'b01 || wb_wd[4:0] !== 5'd3 || wb_wdata[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pass_wb: got wreg=%b wd0=%0d data0=%h want 01 3 deadbeef",
                     wb_wreg, wb_wd[4:0], wb_wdata[31:0]);
        end
        set_idle();
        cycle();
        cycle();
        checks++;
        if (debug_commit_valid !== 2'b01 || debug_commit_pc[31:0] !== 32'h1C000000
            || debug_commit_instr[31:0] !== 32'h00100093) begin
            errors++;
            $display("FAIL pass_debug: got valid=%b pc0=%h instr0=%h want 01 1c000000 00100093",
                     debug_commit_valid, debug_commit_pc[31:0], debug_commit_instr[31:0]);
        end
        cycle();
        checks++;
        if (commit_count !== CNT_W'(base + 1)) begin
            errors++;
            $display("FAIL pass_count: got %0d want %0d", commit_count, (base + 1) % 16);
        end
    endtask

    task automatic test_r0_invalid();
        int base;
        drain();
        base = m_count;
        set_random();
        mem_wd = {5'd7, 5'd0}; mem_wreg = 2'b11; mem_inst_valid = 2'b01;
        cycle();
        checks++;
        if (wb_wreg !== 2'b00 || wb_wd !== {5'd7, 5'd0}) begin
            errors++;
            $display("FAIL r0_invalid_wb: got wreg=%b wd=%h want 00 %h", wb_wreg, wb_wd, {5'd7, 5'd0});
        end
        set_idle();
        cycle();
        cycle();
        checks++;
        if (debug_commit_valid !== 2'b01) begin
            errors++;
            $display("FAIL r0_invalid_debug: got %b want 01", debug_commit_valid);
        end
        cycle();
        checks++;
        if (commit_count !== CNT_W'(base + 1)) begin
            errors++;
            $display("FAIL r0_invalid_count: got %0d want %0d", commit_count, (base + 1) % 16);
        end
    endtask

    task automatic test_stall_hold();
        int base, pulses, bad;
        logic [LANES*REG_AW-1:0] h_wd;
        logic [LANES-1:0]        h_wreg;
        logic [LANES*DATA_W-1:0] h_data;
        drain();
        base = m_count;
        set_random();
        mem_wd[4:0] = 5'd12; mem_wreg = 2'b01; mem_inst_valid = 2'b01;
        h_wd = mem_wd; h_data = mem_wdata; h_wreg = 2'b01;
        cycle();
        pulses = (debug_commit_valid != '0) ? 1 : 0;
        bad = 0;
        stall = 1'b1;
        repeat (4) begin
            set_random();
            cycle();
            if (debug_commit_valid != '0) pulses++;
            if (wb_wd !== h_wd || wb_wreg !== h_wreg || wb_wdata !== h_data) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold_wb: %0d stall cycles changed wb, now wd=%h wreg=%b want wd=%h wreg=%b",
                     bad, wb_wd, wb_wreg, h_wd, h_wreg);
        end
        set_idle();
        repeat (CD + 2) begin
            cycle();
            if (debug_commit_valid != '0) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL stall_hold_pulses: got %0d pulses want 1", pulses);
        end
        checks++;
        if (commit_count !== CNT_W'(base + 1)) begin
            errors++;
            $display("FAIL stall_hold_count: got %0d want %0d", commit_count, (base + 1) % 16);
        end
    endtask

    task automatic test_flush_priority();
        int base, pulses;
        drain();
        base = m_count;
        set_random();
        mem_wd = {5'd4, 5'd5}; mem_wreg = 2'b11; mem_inst_valid = 2'b11;
        stall = 1'b1; flush = 1'b1;
        cycle();
        checks++;
        if (wb_wreg !== 2'b00 || wb_wd !== '0 || wb_wdata !== '0) begin
            errors++;
            $display("FAIL flush_wb: got wreg=%b wd=%h wdata=%h want all 0", wb_wreg, wb_wd, wb_wdata);
        end
        set_idle();
        pulses = 0;
        repeat (CD + 1) begin
            cycle();
            if (debug_commit_valid != '0) pulses++;
        end
        checks++;
        if (pulses != 0 || commit_count !== CNT_W'(base)) begin
            errors++;
            $display("FAIL flush_debug: got %0d pulses count=%0d want 0 pulses count=%0d",
                     pulses, commit_count, base % 16);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        drain();
        set_random();
        mem_wd = {5'd1, 5'd2}; mem_wreg = 2'b11; mem_inst_valid = 2'b11;
        cycle();
        set_random();
        mem_inst_valid = 2'b11;
        cycle();
        rst = 1'b1;
        #1;   // still well before the next clock edge
        checks++;
        if ({wb_wd, wb_wreg, wb_wdata, debug_commit_valid, commit_count} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got wd=%h wreg=%b valid=%b count=%0d want all 0",
                     wb_wd, wb_wreg, debug_commit_valid, commit_count);
        end
        #1;
        rst = 1'b0;
        model_reset();
        set_idle();
        pulses = 0;
        repeat (CD + 3) begin
            cycle();
            if (debug_commit_valid != '0) pulses++;
        end
        checks++;
        if (pulses != 0 || commit_count !== '0) begin
            errors++;
            $display("FAIL async_reset_stale: got %0d pulses count=%0d want 0 and 0", pulses, commit_count);
        end
    endtask

    task automatic test_wrap();
        drain();
        repeat (7) begin
            set_random();
            mem_inst_valid = 2'b11;
            cycle();
        end
        drain();
        checks++;
        if (commit_count !== CNT_W'(m_count) || m_count != 14) begin
            errors++;
            $display("FAIL wrap_preload: got %0d want 14 (model %0d)", commit_count, m_count);
        end
        set_random();
        mem_inst_valid = 2'b11;
        cycle();
        set_idle();
        cycle();
        cycle();
        checks++;
        if (debug_commit_valid !== 2'b11 || commit_count !== 4'd14) begin
            errors++;
            $display("FAIL wrap_dual_pulse: got valid=%b count=%0d want 11 and 14",
                     debug_commit_valid, commit_count);
        end
        cycle();
        checks++;
        if (commit_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 0", commit_count);
        end
    endtask

    task automatic test_random();
        cap_t e;
        logic bad;
        for (int n = 0; n < 400; n++) begin
            set_random();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            cycle();
            e = exp_dbg();
            checks++;
            if (wb_wd !== m_wd || wb_wreg !== m_wreg || wb_wdata !== m_wdata) begin
                errors++;
                $display("FAIL random_wb[%0d]: got wd=%h wreg=%b wdata=%h want wd=%h wreg=%b wdata=%h",
                         n, wb_wd, wb_wreg, wb_wdata, m_wd, m_wreg, m_wdata);
            end
            bad = (debug_commit_valid !== e.v);
            for (int l = 0; l < LANES; l++) begin
                if (e.v[l] && (debug_commit_pc[l*DATA_W +: DATA_W] !== e.pc[l*DATA_W +: DATA_W]
                            || debug_commit_instr[l*DATA_W +: DATA_W] !== e.instr[l*DATA_W +: DATA_W]))
                    bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL random_debug[%0d]: got valid=%b pc=%h instr=%h want valid=%b pc=%h instr=%h",
                         n, debug_commit_valid, debug_commit_pc, debug_commit_instr, e.v, e.pc, e.instr);
            end
            checks++;
            if (commit_count !== CNT_W'(m_count)) begin
                errors++;
                $display("FAIL random_count[%0d]: got %0d want %0d", n, commit_count, m_count);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_passthrough();
        test_r0_invalid();
        test_stall_hold();
        test_flush_priority();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_wb_multi
`default_nettype wire

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
- Parametrised MEM→WB pipeline register for an N-issue core; one lane per issue slot.
- Adds over the single-lane stage:
  - stall (hold) and flush (bubble) control;
  - write-enable qualification, so invalid lanes and r0 writes never reach the regfile;
  - a configurable-depth debug-commit delay line whose pc, instr and valid fields stay aligned;
  - a committed-instruction counter.
- Sits between the MEM stage and the regfile write ports / difftest commit interface.

Parameters:
- LANES, 2, number of issue lanes (1..4).
- DATA_W, 32, width of register data, PC and instruction.
- REG_AW, 5, register address width.
- COMMIT_DELAY, 2, extra cycles between WB capture and the debug_commit_* outputs (0..4).
- CNT_W, 32, width of commit_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  1  hold WB contents; MEM inputs are not consumed.
- flush  in  1  load a bubble into WB this cycle.
- mem_wd  in  LANES*REG_AW  destination register per lane; lane i at [i*REG_AW +: REG_AW].
- mem_wreg  in  LANES  write request per lane.
- mem_wdata  in  LANES*DATA_W  write data per lane.
- mem_inst_pc  in  LANES*DATA_W  PC per lane.
- mem_instr  in  LANES*DATA_W  instruction word per lane.
- mem_inst_valid  in  LANES  lane holds a real instruction.
- wb_wd  out  LANES*REG_AW  registered destination.
- wb_wreg  out  LANES  qualified regfile write enable.
- wb_wdata  out  LANES*DATA_W  registered write data.
- debug_commit_pc  out  LANES*DATA_W  delayed commit PC.
- debug_commit_instr  out  LANES*DATA_W  delayed commit instruction.
- debug_commit_valid  out  LANES  delayed commit strobe, one pulse per instruction.
- commit_count  out  CNT_W  running count of committed instructions.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-high. The design is fully in the clk domain.
- Reset values (all outputs and internal state): wb_wd=0, wb_wreg=0, wb_wdata=0, all debug_commit_* =0, every delay-line stage =0, commit_count=0.
- Control priority per cycle: flush > stall > normal advance.
- Normal advance (stall=0, flush=0), per lane, in 1 cycle:
  - wb_wd, wb_wdata ← mem_wd, mem_wdata;
  - wb_wreg ← mem_wreg & mem_inst_valid & (mem_wd≠0);
  - capture_valid ← mem_inst_valid, and the lane's pc/instr are captured.
- Stall: all wb_* hold their values and capture_valid=0. An instruction already in WB is never reported twice, and the regfile write is idempotent.
- Flush: wb_wreg=0, wb_wd=0, wb_wdata=0 and capture_valid=0 for all lanes. If stall and flush are asserted together, flush wins.
- Reset mid-operation: everything clears immediately, including in-flight delay-line entries and the counter. No commit pulse is emitted for the lost entries.
- Debug delay line:
  - COMMIT_DELAY+1 registers total; the first is the WB capture.
  - It advances every cycle regardless of stall.
  - pc, instr and valid all pass through identical stages, so they are always aligned (unlike the old stage, where only valid was delayed).
  - With COMMIT_DELAY=0, debug outputs change in the same cycle as wb_*.
  - Total latency from mem_* inputs to debug_commit_*: COMMIT_DELAY+1 cycles.
  - pc and instr of a lane whose valid is 0 are don't-care but deterministic; they are registered unconditionally.
- commit_count:
  - Each cycle, increments by the popcount of debug_commit_valid at the output tap, i.e. it counts reported commits.
  - Update is registered, so the count reflects a pulse one cycle after that pulse is visible.
  - Wraps modulo 2^CNT_W with no saturation.
- Lane independence: lanes never interact; write-after-write ordering inside a bundle is resolved by the regfile (higher lane wins).
- Out-of-range parameter values (LANES outside 1..4, COMMIT_DELAY outside 0..4) are rejected by an elaboration-time error.

Decomposition:
- Shared package `pipe_pkg`:
  - typedef `wb_lane_t` {wd, wreg, wdata};
  - typedef `commit_lane_t` {pc, instr, valid};
  - constants for default data width, register address width and the NOP register address.
- One natural sub-module, `commit_delay_line`: parametrised depth, width LANES*(2*DATA_W+1), free-running shift with async clear; the counter logic stays in mem_wb_multi.

Test Plan:
- Reset and basic pass-through: rst pulse mid-run, then LANES=2, COMMIT_DELAY=2; lane0 {wd=3, wreg=1, data=0xDEADBEEF, pc=0x1C000000, valid=1}, lane1 invalid.
  - Next edge: wb_wreg=2'b01, wb_wd[0]=3.
  - 3 edges after input: debug_commit_valid=2'b01, pc=0x1C000000.
  - One cycle later: commit_count=1.
- r0 and invalid suppression: lane0 wd=0, wreg=1, valid=1; lane1 wd=7, wreg=1, valid=0.
  - wb_wreg=2'b00.
  - debug_commit_valid later =2'b01; commit_count +1.
- Stall hold: a valid bundle captured, then stall held for 4 cycles.
  - wb_* constant for 4 cycles.
  - Exactly one debug_commit_valid pulse, and commit_count increments once.
- Flush priority: stall=1 and flush=1 with valid MEM inputs.
  - Next edge: wb_wreg=0, wb_wd=0.
  - No debug pulse COMMIT_DELAY cycles later.
- Async reset mid-flight: two bundles inside the delay line, rst asserted between edges.
  - Outputs go to 0 before the next clk edge.
  - After release, no stale commit pulses and commit_count=0.
- Counter wrap and dual commit: CNT_W=4, preload 14 commits, then a bundle with both lanes valid.
  - commit_count goes 14→0 (+2 modulo 16).
